// File: rtl/crop_norm_buf.sv
// crop_norm_buf: self-counting frame capture of a clamped crop window with max search,
// once-per-frame reciprocal and buffered normalised/truncated AXI-stream output.
module crop_norm_buf #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int OUT_BIT_WIDTH   = 8,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10,
    parameter int FRAC_BITS       = 16
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        ap_start,
    output logic                        ap_ready,
    output logic                        ap_done,
    input  logic                        norm_en,
    input  logic [$clog2(IN_COLS)-1:0]  crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0]  crop_y0,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]  s_axis_tdata,
    input  logic                        s_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [OUT_BIT_WIDTH-1:0]    m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic [PIXEL_BIT_WIDTH-1:0]  roi_max,
    output logic                        resync
);
    localparam int PW   = PIXEL_BIT_WIDTH;
    localparam int OW   = OUT_BIT_WIDTH;
    localparam int F    = FRAC_BITS;
    localparam int D    = OW + F;
    localparam int PD   = PW + D;
    localparam int NPIX = OUT_ROWS * OUT_COLS;
    localparam int CW   = $clog2(IN_COLS);
    localparam int RW   = $clog2(IN_ROWS);
    localparam int AW   = $clog2(NPIX + 1);
    localparam int IW   = $clog2(NPIX);
    localparam int DCW  = $clog2(D);
    localparam logic [CW-1:0] XMAX     = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0] YMAX     = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [D-1:0]  DIVIDEND = {{OW{1'b1}}, {F{1'b0}}};
    localparam logic [PD:0]   HALF     = (PD+1)'(1) << (F - 1);

    typedef enum logic [2:0] {IDLE, SYNC, CAPTURE, RECIP, STREAM} state_t;
    state_t state, state_d;

    logic          norm_q;
    logic [CW-1:0] x0_q, col, cur_c;
    logic [RW-1:0] y0_q, row, cur_r;
    logic [AW-1:0] wr_ptr, rd_ptr, base_ptr;
    logic [PW-1:0] max_q, base_max, rem, p2, rd_data;
    logic [D-1:0]  quo;
    logic [DCW-1:0] div_cnt;
    logic [PW:0]   rem_t;
    logic          rem_ge, beat, take, in_roi, frame_end, wr_en, en, issue;
    logic          v1, l1, v2, l2;
    logic [PD-1:0] prod;
    logic [PD:0]   rnd_sh;
    logic [OW-1:0] norm_pix, trunc_pix;
    logic [PW-1:0] mem [NPIX];

    assign ap_ready      = state == IDLE;
    assign s_axis_tready = state == SYNC || state == CAPTURE;
    assign roi_max       = max_q;
    assign beat          = s_axis_tvalid && s_axis_tready;
    // In SYNC only a tuser beat is taken; it is processed exactly like a capture pixel at (0,0)
    assign take          = beat && (state == CAPTURE || s_axis_tuser);
    assign cur_c         = s_axis_tuser ? '0 : col;
    assign cur_r         = s_axis_tuser ? '0 : row;
    assign base_ptr      = s_axis_tuser ? '0 : wr_ptr;
    assign base_max      = s_axis_tuser ? '0 : max_q;
    assign in_roi        = {1'b0, cur_c} >= {1'b0, x0_q} && {1'b0, cur_c} < {1'b0, x0_q} + (CW+1)'(OUT_COLS)
                        && {1'b0, cur_r} >= {1'b0, y0_q} && {1'b0, cur_r} < {1'b0, y0_q} + (RW+1)'(OUT_ROWS);
    assign frame_end     = cur_r == RW'(IN_ROWS - 1) && cur_c == CW'(IN_COLS - 1);
    assign wr_en         = take && in_roi;
    assign en            = !m_axis_tvalid || m_axis_tready;
    assign issue         = state == STREAM && rd_ptr != AW'(NPIX);
    assign rem_t         = {rem, quo[D-1]};
    assign rem_ge        = rem_t >= {1'b0, max_q};
    assign rnd_sh        = ({1'b0, prod} + HALF) >> F;
    assign norm_pix      = |rnd_sh[PD:OW] ? '1 : rnd_sh[OW-1:0];
    assign trunc_pix     = OW'(p2 >> (PW - OW));

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = ap_start ? SYNC : IDLE;
            SYNC:    state_d = take ? CAPTURE : SYNC;
            CAPTURE: state_d = take && frame_end ? (norm_q ? RECIP : STREAM) : CAPTURE;
            RECIP:   state_d = max_q == '0 || div_cnt == DCW'(D - 1) ? STREAM : RECIP;
            STREAM:  state_d = m_axis_tvalid && m_axis_tready && m_axis_tlast ? IDLE : STREAM;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state         <= IDLE;
            ap_done       <= 1'b0;
            resync        <= 1'b0;
            norm_q        <= 1'b0;
            x0_q          <= '0;
            y0_q          <= '0;
            col           <= '0;
            row           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            max_q         <= '0;
            rem           <= '0;
            quo           <= '0;
            div_cnt       <= '0;
            v1            <= 1'b0;
            l1            <= 1'b0;
            v2            <= 1'b0;
            l2            <= 1'b0;
            prod          <= '0;
            p2            <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            state   <= state_d;
            ap_done <= state == STREAM && m_axis_tvalid && m_axis_tready && m_axis_tlast;
            resync  <= state == CAPTURE && beat && s_axis_tuser;
            if (state == IDLE && ap_start) begin
                norm_q <= norm_en;
                x0_q   <= crop_x0 > XMAX ? XMAX : crop_x0;
                y0_q   <= crop_y0 > YMAX ? YMAX : crop_y0;
                rd_ptr <= '0;
            end
            if (take) begin
                col    <= cur_c == CW'(IN_COLS - 1) ? '0 : cur_c + CW'(1);
                row    <= cur_c == CW'(IN_COLS - 1) ? cur_r + RW'(1) : cur_r;
                wr_ptr <= base_ptr + AW'(in_roi);
                max_q  <= in_roi && s_axis_tdata > base_max ? s_axis_tdata : base_max;
            end
            if (state == CAPTURE && state_d == RECIP) begin
                rem     <= '0;
                quo     <= DIVIDEND;
                div_cnt <= '0;
            end
            // Restoring divider: quo shifts dividend bits out at the top and quotient bits in at the bottom
            if (state == RECIP) begin
                if (max_q == '0) begin
                    quo <= '0;
                end else begin
                    rem     <= rem_ge ? PW'(rem_t - {1'b0, max_q}) : rem_t[PW-1:0];
                    quo     <= {quo[D-2:0], rem_ge};
                    div_cnt <= div_cnt + DCW'(1);
                end
            end
            // Whole read/multiply/output pipeline advances together and freezes on a stalled output
            if (en) begin
                v1            <= issue;
                l1            <= rd_ptr == AW'(NPIX - 1);
                v2            <= v1;
                l2            <= l1;
                prod          <= PD'(rd_data) * PD'(quo);
                p2            <= rd_data;
                m_axis_tvalid <= v2;
                m_axis_tlast  <= l2;
                m_axis_tdata  <= norm_q ? norm_pix : trunc_pix;
                if (issue)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[IW'(base_ptr)] <= s_axis_tdata;
        if (en && issue)
            rd_data <= mem[IW'(rd_ptr)];
    end
endmodule

// File: tb/tb_crop_norm_buf.sv
// tb_crop_norm_buf: table-driven frames with a model-fed output scoreboard,
// plus resync, backpressure and mid-stream reset sequences.
module tb_crop_norm_buf;
    localparam int PW = 10, OW = 8, IR = 8, IC = 8, OR = 4, OC = 4, F = 16;
    localparam int NP = OR * OC;

    logic          clk = 1'b0, srst = 1'b1, ap_start = 1'b0, norm_en = 1'b0;
    logic          ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast, resync;
    logic [2:0]    crop_x0 = '0, crop_y0 = '0;
    logic          s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, m_axis_tready = 1'b1;
    logic [PW-1:0] s_axis_tdata = '0, roi_max;
    logic [OW-1:0] m_axis_tdata;

    always #5 clk = ~clk;

    crop_norm_buf #(.PIXEL_BIT_WIDTH(PW), .OUT_BIT_WIDTH(OW), .IN_ROWS(IR), .IN_COLS(IC),
                    .OUT_ROWS(OR), .OUT_COLS(OC), .FRAC_BITS(F)) dut (
        .clk(clk), .srst(srst), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .norm_en(norm_en), .crop_x0(crop_x0), .crop_y0(crop_y0),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tuser(s_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .roi_max(roi_max), .resync(resync)
    );

    typedef struct {
        bit norm;
        int cx, cy, kind;
        bit stall;
        int junk, resync_at, exp_first, exp_last, exp_max;
    } vec_t;

    vec_t vecs[10];
    int   n_tests = 0, n_fail = 0;
    int   sb[$];
    int   out_idx = 0, done_cnt = 0, resync_cnt = 0, first_d = -1, last_d = -1, exp_v = 0;
    int   held_d = 0;
    bit   held_l = 1'b0, seen_valid = 1'b0, stall_en = 1'b0, stalled_prev = 1'b0;
    time  first_valid_t = 0, last_beat_t = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pix_of(input int kind, input int r, input int c);
        return kind == 0 ? r * IC + c : kind == 1 ? 0 : (r * 131 + c * 29 + 7) % 1024;
    endfunction

    function automatic int model_out(input bit norm, input int p, input int mx);
        longint rc, v;
        if (!norm) return p >> (PW - OW);
        if (mx == 0) return 0;
        rc = (((longint'(1) << OW) - 1) << F) / mx;
        v  = (longint'(p) * rc + (longint'(1) << (F - 1))) >> F;
        return v > 255 ? 255 : int'(v);
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        m_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!srst) begin
            if (ap_done) begin
                done_cnt++;
                chk("done_with_ready", ap_ready, 1);
            end
            if (resync) resync_cnt++;
            if (stalled_prev) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_data", m_axis_tdata, held_d);
                chk("stall_last", m_axis_tlast, held_l);
            end
            if (m_axis_tvalid && !seen_valid) begin
                seen_valid    = 1'b1;
                first_valid_t = $time;
                chk("tready_low_in_stream", s_axis_tready, 0);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0d, expected no output", m_axis_tdata);
                end else begin
                    exp_v = sb.pop_front();
                    chk("pixel", m_axis_tdata, exp_v);
                end
                chk("tlast", m_axis_tlast, out_idx == NP - 1);
                if (out_idx == 0) first_d = m_axis_tdata;
                if (m_axis_tlast) last_d = m_axis_tdata;
                out_idx++;
            end
            stalled_prev = m_axis_tvalid && !m_axis_tready;
            held_d       = m_axis_tdata;
            held_l       = m_axis_tlast;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic beat(input int d, input bit u);
        s_axis_tdata  = 10'(d);
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        last_beat_t = $time;
        @(negedge clk);
    endtask

    task automatic prep(input vec_t v, output int mx);
        int x0, y0;
        x0 = v.cx > IC - OC ? IC - OC : v.cx;
        y0 = v.cy > IR - OR ? IR - OR : v.cy;
        mx = 0;
        for (int r = y0; r < y0 + OR; r++)
            for (int c = x0; c < x0 + OC; c++)
                if (pix_of(v.kind, r, c) > mx) mx = pix_of(v.kind, r, c);
        for (int r = y0; r < y0 + OR; r++)
            for (int c = x0; c < x0 + OC; c++)
                sb.push_back(model_out(v.norm, pix_of(v.kind, r, c), mx));
    endtask

    task automatic start_and_send(input vec_t v);
        for (int k = 0; k < 50 && !ap_ready; k++) @(negedge clk);
        out_idx    = 0;
        seen_valid = 1'b0;
        first_d    = -1;
        last_d     = -1;
        stall_en   = v.stall;
        norm_en    = v.norm;
        crop_x0    = 3'(v.cx);
        crop_y0    = 3'(v.cy);
        ap_start   = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        chk("ready_low_after_start", ap_ready, 0);
        for (int i = 0; i < v.junk; i++) beat(int'($urandom_range(0, 1023)), 1'b0);
        for (int i = 0; i < v.resync_at; i++) beat(1023, i == 0);
        for (int r = 0; r < IR; r++)
            for (int c = 0; c < IC; c++)
                beat(pix_of(v.kind, r, c), r == 0 && c == 0);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int mx, n_done, n_res, lat;
        prep(v, mx);
        n_done = done_cnt;
        n_res  = resync_cnt;
        start_and_send(v);
        for (int k = 0; k < 600 && done_cnt == n_done; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        lat = !v.norm ? 3 : mx != 0 ? OW + F + 3 : -1;
        chk("done_pulses", done_cnt - n_done, 1);
        chk("output_count", out_idx, NP);
        chk("queue_empty", sb.size(), 0);
        chk("resync_pulses", resync_cnt - n_res, v.resync_at > 0);
        chk("roi_max", roi_max, v.exp_max >= 0 ? v.exp_max : mx);
        chk("ready_after_frame", ap_ready, 1);
        if (lat >= 0) chk("first_valid_latency", int'((first_valid_t - last_beat_t) / 10), lat);
        if (v.exp_first >= 0) begin
            chk("first_pixel", first_d, v.exp_first);
            chk("last_pixel", last_d, v.exp_last);
        end
        stall_en = 1'b0;
        sb.delete();
    endtask

    task automatic reset_mid(input vec_t v);
        int mx, n_done;
        prep(v, mx);
        start_and_send(v);
        for (int k = 0; k < 600 && out_idx < 7; k++) @(posedge clk);
        #1;
        n_done = done_cnt;
        srst   = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_ready", ap_ready, 1);
        @(negedge clk);
        srst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_output_count", out_idx, 7);
        chk("abort_no_done", done_cnt - n_done, 0);
        chk("abort_tvalid_stays_low", m_axis_tvalid, 0);
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{1, 2, 3, 0, 0, 0, 0, 125, 255, 53};
        vecs[1] = '{0, 2, 3, 0, 0, 0, 0, 6, 13, 53};
        vecs[2] = '{0, 7, 7, 0, 0, 0, 0, 9, 15, 63};
        vecs[3] = '{1, 2, 3, 1, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{1, 2, 3, 0, 1, 0, 0, 125, 255, 53};
        vecs[5] = '{1, 2, 3, 0, 0, 5, 0, 125, 255, 53};
        vecs[6] = '{1, 0, 0, 0, 0, 0, 20, 0, 255, 27};
        vecs[7] = '{1, 1, 0, 2, 1, 0, 0, -1, -1, -1};
        vecs[8] = '{0, 0, 4, 2, 0, 2, 0, -1, -1, -1};
        vecs[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 255, 27};
        repeat (3) @(negedge clk);
        chk("rst_ap_ready", ap_ready, 1);
        chk("rst_ap_done", ap_done, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_roi_max", roi_max, 0);
        chk("rst_resync", resync, 0);
        srst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) run_frame(vecs[i]);
        reset_mid(vecs[0]);
        run_frame(vecs[0]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
